// File: rtl/v1_deque_pkg.sv
// Shared types for the op-centric deque: op encoding and pointer-width helper.
package v1_deque_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH_BACK,
        OP_PUSH_FRONT,
        OP_POP_FRONT,
        OP_POP_BACK
    } op_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/v1_op_centric_deque_storage.sv
// Deque register file: one write port, combinational reads at head and tail-1.
module v1_DequeStorage
    import v1_deque_pkg::*;
#(
    parameter int p_depth    = 8,
    parameter int p_bitwidth = 32
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [ptr_w(p_depth)-1:0]    wr_addr_i,
    input  logic [p_bitwidth-1:0]        wr_data_i,
    input  logic [ptr_w(p_depth)-1:0]    rd_head_addr_i,
    input  logic [ptr_w(p_depth)-1:0]    rd_tail_addr_i,
    output logic [p_bitwidth-1:0]        rd_head_data_o,
    output logic [p_bitwidth-1:0]        rd_tail_data_o
);

    logic [p_bitwidth-1:0] mem_q [p_depth];

    // Contents are deliberately not reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_head_data_o = mem_q[rd_head_addr_i];
    assign rd_tail_data_o = mem_q[rd_tail_addr_i];

endmodule

// File: rtl/v1_op_centric_deque.sv
// Double-ended op-centric queue with push/pop at both ends on one storage array.
// Optional sticky protocol-error detection is compiled in with V1_DEQUE_ERR_EN.
module v1_op_centric_deque
    import v1_deque_pkg::*;
#(
    parameter int p_depth    = 8,
    parameter int p_bitwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_back_en,
    output logic                  push_back_rdy,
    input  logic [p_bitwidth-1:0] push_back_data,
    input  logic                  push_front_en,
    output logic                  push_front_rdy,
    input  logic [p_bitwidth-1:0] push_front_data,
    input  logic                  pop_front_en,
    output logic                  pop_front_rdy,
    output logic [p_bitwidth-1:0] pop_front_data,
    input  logic                  pop_back_en,
    output logic                  pop_back_rdy,
    output logic [p_bitwidth-1:0] pop_back_data,
    output logic                  err
);

    localparam int            PW       = ptr_w(p_depth);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(p_depth);

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]         head_m1, tail_m1;
    logic [PW:0]           count_q, count_d;
    logic                  push_rdy_q, pop_rdy_q;
    logic [p_bitwidth-1:0] pop_front_data_q, pop_back_data_q;
    logic                  wr_en;
    logic [PW-1:0]         wr_addr;
    logic [p_bitwidth-1:0] wr_data, rd_head, rd_tail;
    op_e                   push_op, pop_op;

    assign head_m1 = head_q - PW'(1);
    assign tail_m1 = tail_q - PW'(1);

    // Both pushes share one rdy (not full), both pops share one (not empty);
    // back wins among pushes, front wins among pops.
    always_comb begin
        push_op = OP_NONE;
        if (push_rdy_q && push_back_en) begin
            push_op = OP_PUSH_BACK;
        end else if (push_rdy_q && push_front_en) begin
            push_op = OP_PUSH_FRONT;
        end
        pop_op = OP_NONE;
        if (pop_rdy_q && pop_front_en) begin
            pop_op = OP_POP_FRONT;
        end else if (pop_rdy_q && pop_back_en) begin
            pop_op = OP_POP_BACK;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = tail_q;
        wr_data = push_back_data;
        case (push_op)
            OP_PUSH_BACK: begin
                wr_en   = 1'b1;
                wr_data = push_back_data;
                // Same-end push+pop replaces the popped slot in place.
                if (pop_op == OP_POP_BACK) begin
                    wr_addr = tail_m1;
                end else begin
                    wr_addr = tail_q;
                    tail_d  = tail_q + PW'(1);
                end
            end
            OP_PUSH_FRONT: begin
                wr_en   = 1'b1;
                wr_data = push_front_data;
                if (pop_op == OP_POP_FRONT) begin
                    wr_addr = head_q;
                end else begin
                    wr_addr = head_m1;
                    head_d  = head_m1;
                end
            end
            default: ;
        endcase
        case (pop_op)
            OP_POP_FRONT: if (push_op != OP_PUSH_FRONT) head_d = head_q + PW'(1);
            OP_POP_BACK:  if (push_op != OP_PUSH_BACK)  tail_d = tail_m1;
            default: ;
        endcase
        if (push_op != OP_NONE && pop_op == OP_NONE) begin
            count_d = count_q + 1'b1;
        end else if (push_op == OP_NONE && pop_op != OP_NONE) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            push_rdy_q       <= 1'b1;
            pop_rdy_q        <= 1'b0;
            pop_front_data_q <= '0;
            pop_back_data_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            push_rdy_q <= (count_d != FULL_CNT);
            pop_rdy_q  <= (count_d != '0);
            if (pop_op == OP_POP_FRONT) pop_front_data_q <= rd_head;
            if (pop_op == OP_POP_BACK)  pop_back_data_q  <= rd_tail;
        end
    end

    v1_DequeStorage #(
        .p_depth    (p_depth),
        .p_bitwidth (p_bitwidth)
    ) u_storage (
        .clk            (clk),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .rd_head_addr_i (head_q),
        .rd_tail_addr_i (tail_m1),
        .rd_head_data_o (rd_head),
        .rd_tail_data_o (rd_tail)
    );

    assign push_back_rdy  = push_rdy_q;
    assign push_front_rdy = push_rdy_q;
    assign pop_front_rdy  = pop_rdy_q;
    assign pop_back_rdy   = pop_rdy_q;
    assign pop_front_data = pop_front_data_q;
    assign pop_back_data  = pop_back_data_q;

`ifdef V1_DEQUE_ERR_EN
    logic err_q, err_set;

    assign err_set = (push_back_en  && !push_rdy_q) || (push_front_en && !push_rdy_q) ||
                     (pop_front_en  && !pop_rdy_q)  || (pop_back_en   && !pop_rdy_q)  ||
                     (push_back_en  && push_front_en) || (pop_front_en && pop_back_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_v1_op_centric_deque.sv
// Bench for v1_op_centric_deque: queue-based reference model, directed scenarios, random traffic.
module tb_v1_op_centric_deque;

    localparam int DEPTH = 4;
    localparam int BW    = 8;
`ifdef V1_DEQUE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_back_en = 1'b0, push_front_en = 1'b0;
    logic          pop_front_en = 1'b0, pop_back_en = 1'b0;
    logic [BW-1:0] push_back_data = '0, push_front_data = '0;
    logic          push_back_rdy, push_front_rdy, pop_front_rdy, pop_back_rdy, err;
    logic [BW-1:0] pop_front_data, pop_back_data;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [BW-1:0] mq[$];
    logic [BW-1:0] m_pf = '0, m_pb = '0;
    bit            m_err = 1'b0;
    int            m_sz;
    bit            do_pb, do_pf, do_popf, do_popb;

    v1_op_centric_deque #(.p_depth(DEPTH), .p_bitwidth(BW)) dut (
        .clk             (clk),
        .rst             (rst),
        .push_back_en    (push_back_en),
        .push_back_rdy   (push_back_rdy),
        .push_back_data  (push_back_data),
        .push_front_en   (push_front_en),
        .push_front_rdy  (push_front_rdy),
        .push_front_data (push_front_data),
        .pop_front_en    (pop_front_en),
        .pop_front_rdy   (pop_front_rdy),
        .pop_front_data  (pop_front_data),
        .pop_back_en     (pop_back_en),
        .pop_back_rdy    (pop_back_rdy),
        .pop_back_data   (pop_back_data),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pops are taken first (from the pre-edge occupancy), then the push is applied.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_pf  = '0;
            m_pb  = '0;
            m_err = 1'b0;
        end else begin
            m_sz    = mq.size();
            do_pb   = push_back_en && (m_sz < DEPTH);
            do_pf   = push_front_en && !push_back_en && (m_sz < DEPTH);
            do_popf = pop_front_en && (m_sz > 0);
            do_popb = pop_back_en && !pop_front_en && (m_sz > 0);
            if (do_popf) m_pf = mq.pop_front();
            if (do_popb) m_pb = mq.pop_back();
            if (do_pb) mq.push_back(push_back_data);
            if (do_pf) mq.push_front(push_front_data);
            if (ERR_ON && ((push_back_en && m_sz == DEPTH) || (push_front_en && m_sz == DEPTH) ||
                           (pop_front_en && m_sz == 0) || (pop_back_en && m_sz == 0) ||
                           (push_back_en && push_front_en) || (pop_front_en && pop_back_en)))
                m_err = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("push_back_rdy",  push_back_rdy,  32'(mq.size() < DEPTH));
            check("push_front_rdy", push_front_rdy, 32'(mq.size() < DEPTH));
            check("pop_front_rdy",  pop_front_rdy,  32'(mq.size() > 0));
            check("pop_back_rdy",   pop_back_rdy,   32'(mq.size() > 0));
            check("pop_front_data", pop_front_data, 32'(m_pf));
            check("pop_back_data",  pop_back_data,  32'(m_pb));
            check("err",            err,            32'(m_err));
        end
    end

    task automatic step(input logic pbe, input logic [BW-1:0] pbd, input logic pfe,
                        input logic [BW-1:0] pfd, input logic popf, input logic popb);
        push_back_en    = pbe;
        push_back_data  = pbd;
        push_front_en   = pfe;
        push_front_data = pfd;
        pop_front_en    = popf;
        pop_back_en     = popb;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    logic [BW-1:0] exp_seq [4];

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset push_back_rdy", push_back_rdy, 32'h1);
        check("reset pop_front_rdy", pop_front_rdy, 32'h0);
        check("reset pop_back_data", pop_back_data, 32'h0);
        rst = 1'b0;

        // FIFO order, full/empty flags
        step(1, 8'h11, 0, '0, 0, 0);
        step(1, 8'h22, 0, '0, 0, 0);
        step(1, 8'h33, 0, '0, 0, 0);
        step(1, 8'h44, 0, '0, 0, 0);
        check("full push_back_rdy", push_back_rdy, 32'h0);
        check("full push_front_rdy", push_front_rdy, 32'h0);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, '0, 1, 0);
            check("fifo pop_front_data", pop_front_data, 32'(exp_seq[i]));
        end
        check("drained pop_front_rdy", pop_front_rdy, 32'h0);

        // LIFO order from the back
        step(1, 8'h11, 0, '0, 0, 0);
        step(1, 8'h22, 0, '0, 0, 0);
        step(1, 8'h33, 0, '0, 0, 0);
        step(1, 8'h44, 0, '0, 0, 0);
        exp_seq = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 0, '0, 0, 1);
            check("lifo pop_back_data", pop_back_data, 32'(exp_seq[i]));
        end

        // Head wraps below index 0
        do_reset();
        step(0, '0, 1, 8'hA1, 0, 0);
        step(0, '0, 1, 8'hA2, 0, 0);
        step(1, 8'hB1, 0, '0, 0, 0);
        exp_seq = '{8'hA2, 8'hA1, 8'hB1, 8'h00};
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, '0, 1, 0);
            check("wrap pop_front_data", pop_front_data, 32'(exp_seq[i]));
        end

        // Push while full is ignored; same-end push+pop replaces the tail
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, '0, 0, 0);
        step(1, 8'h55, 0, '0, 1, 0);
        check("full push+pop_front data", pop_front_data, 32'h01);
        check("full push ignored rdy", push_back_rdy, 32'h1);
        step(1, 8'h55, 0, '0, 0, 1);
        check("push+pop_back data", pop_back_data, 32'h04);
        step(0, '0, 0, '0, 0, 1);
        check("replaced tail", pop_back_data, 32'h55);
        step(0, '0, 0, '0, 1, 0);
        check("drain front 1", pop_front_data, 32'h02);
        step(0, '0, 0, '0, 1, 0);
        check("drain front 2", pop_front_data, 32'h03);

        // Pop on empty
        do_reset();
        step(0, '0, 0, '0, 1, 0);
        check("empty pop data", pop_front_data, 32'h0);
        check("empty pop err", err, 32'(ERR_ON));
        idle();
        check("err sticky", err, 32'(ERR_ON));
        do_reset();
        check("err cleared", err, 32'h0);

        // Reset mid-operation
        step(1, 8'h77, 0, '0, 0, 0);
        step(1, 8'h88, 0, '0, 0, 0);
        do_reset();
        check("post-rst push rdy", push_back_rdy, 32'h1);
        check("post-rst pop rdy", pop_front_rdy, 32'h0);
        step(0, '0, 0, '0, 1, 0);
        step(0, '0, 0, '0, 1, 0);
        check("post-rst held pop rdy", pop_front_rdy, 32'h0);
        check("post-rst held pop data", pop_front_data, 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(logic'($urandom_range(0, 9) < 4), 8'($urandom),
                 logic'($urandom_range(0, 9) < 3), 8'($urandom),
                 logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) < 3));
        end
        rst = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
